// File: rtl/turing_engine_pkg.sv
// Shared types for the Turing-machine engine: FSM states, result codes and
// the rule-entry layout at the default state/symbol widths.
package tm_pkg;

    typedef enum logic [2:0] {
        IDLE, CLR, CLRW, RD, LOOK, WR, STEP, FIN
    } tm_state_e;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_HALT  = 2'd1,
        RES_LIMIT = 2'd2,
        RES_STOP  = 2'd3
    } tm_result_e;

    localparam int unsigned TM_QBITS = 2;
    localparam int unsigned TM_SBITS = 4;

    localparam logic [TM_QBITS-1:0] HALT = '1;

    typedef struct packed {
        logic [TM_SBITS-1:0] newsym;
        logic                dir;
        logic [TM_QBITS-1:0] next;
    } tm_rule_t;

endpackage

// File: rtl/turing_engine_if.sv
// Tape memory handshake between the engine (master) and the DRAM controller.
interface turing_engine_if #(
    parameter int unsigned ABITS = 18,
    parameter int unsigned SBITS = 4
);
    logic [ABITS-1:0] m_addr;
    logic             m_write;
    logic             m_ena;
    logic [SBITS-1:0] wr_data;
    logic [SBITS-1:0] rd_data;
    logic             m_busy;
    logic             m_ack;

    modport master (
        output m_addr, m_write, m_ena, wr_data,
        input  rd_data, m_busy, m_ack
    );

    modport slave (
        input  m_addr, m_write, m_ena, wr_data,
        output rd_data, m_busy, m_ack
    );
endinterface

// File: rtl/turing_engine_rule_ram.sv
// Transition table: synchronous RAM, one write port, one enabled read port.
// Contents are deliberately not reset.
module tm_rule_ram #(
    parameter int unsigned AW = 6,
    parameter int unsigned DW = 7
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);
    logic [DW-1:0] r_mem [0:(1 << AW)-1];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/turing_engine.sv
// Turing-machine engine: run-time loaded transition table, tape held in
// external memory, step/sigma counters and termination reporting.
module turing_engine
    import tm_pkg::*;
#(
    parameter int unsigned ABITS = 18,
    parameter int unsigned SBITS = 4,
    parameter int unsigned QBITS = 2,
    parameter int unsigned CBITS = 40
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop,
    input  logic [CBITS-1:0]       max_steps,
    input  logic                   rule_we,
    input  logic [QBITS+SBITS-1:0] rule_addr,
    input  logic [SBITS+QBITS:0]   rule_data,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             result,
    output logic                   wrapped,
    output logic [CBITS-1:0]       steps,
    output logic [CBITS-1:0]       sigma,
    output logic [ABITS-1:0]       head,
    turing_engine_if.master        mem
);
    typedef struct packed {
        logic [SBITS-1:0] newsym;
        logic             dir;
        logic [QBITS-1:0] next;
    } rule_t;

    localparam logic [QBITS-1:0] Q_HALT = '1;
    localparam logic [ABITS-1:0] A_MID  = {1'b1, {(ABITS-1){1'b0}}};

    tm_state_e        r_state, w_state_nxt;
    tm_result_e       r_result, w_step_result;
    logic [QBITS-1:0] r_q;
    logic [SBITS-1:0] r_sym;
    logic [ABITS-1:0] r_addr, r_head, w_head_nxt;
    logic [CBITS-1:0] r_steps, r_sigma, w_steps_inc;
    logic             r_wrapped, r_stop_pend, r_acked, r_ena_q;
    logic             w_req, w_write, w_ram_re, w_xfer_done;
    logic             w_stop_any, w_limit, w_cross;
    logic [SBITS+QBITS:0] w_ram_rdata;
    rule_t            w_rule;

    tm_rule_ram #(.AW(QBITS+SBITS), .DW(SBITS+QBITS+1)) u_rules (
        .clk     (clk),
        .i_we    (rule_we && !busy),
        .i_waddr (rule_addr),
        .i_wdata (rule_data),
        .i_re    (w_ram_re),
        .i_raddr ({r_q, mem.rd_data}),
        .o_rdata (w_ram_rdata)
    );

    assign w_rule      = w_ram_rdata;
    assign w_xfer_done = (mem.m_ack || r_acked) && !mem.m_busy;
    assign w_stop_any  = r_stop_pend || stop;
    assign w_steps_inc = (r_steps == '1) ? r_steps : r_steps + CBITS'(1);
    assign w_limit     = (max_steps != '0) && (w_steps_inc == max_steps);
    assign w_head_nxt  = w_rule.dir ? r_head + ABITS'(1) : r_head - ABITS'(1);
    assign w_cross     = w_rule.dir ? (r_head == '1) : (r_head == '0);

    always_comb begin
        w_step_result = RES_NONE;
        if (w_rule.next == Q_HALT) w_step_result = RES_HALT;
        else if (w_limit)          w_step_result = RES_LIMIT;
        else if (w_stop_any)       w_step_result = RES_STOP;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_write     = 1'b0;
        w_ram_re    = 1'b0;
        case (r_state)
            IDLE: if (start) w_state_nxt = CLR;
            CLR: begin
                w_req   = 1'b1;
                w_write = 1'b1;
                if (mem.m_ack) w_state_nxt = CLRW;
            end
            CLRW: if (!mem.m_busy) begin
                if (w_stop_any)         w_state_nxt = FIN;
                else if (r_addr == '1)  w_state_nxt = RD;
                else                    w_state_nxt = CLR;
            end
            RD: begin
                w_req = !r_acked;
                if (w_xfer_done) begin
                    w_ram_re    = 1'b1;
                    w_state_nxt = LOOK;
                end
            end
            LOOK: w_state_nxt = (w_rule.newsym == r_sym) ? STEP : WR;
            WR: begin
                w_req   = !r_acked;
                w_write = 1'b1;
                if (w_xfer_done) w_state_nxt = STEP;
            end
            STEP: w_state_nxt = (w_step_result != RES_NONE) ? FIN : RD;
            FIN:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // A request may only rise while the memory is idle; once raised it is held until acked.
    assign mem.m_ena   = w_req && (r_ena_q || !mem.m_busy);
    assign mem.m_write = w_write;
    assign mem.m_addr  = r_addr;
    assign mem.wr_data = (r_state == WR) ? w_rule.newsym : '0;

    assign busy    = (r_state != IDLE);
    assign done    = (r_state == FIN);
    assign result  = r_result;
    assign wrapped = r_wrapped;
    assign steps   = r_steps;
    assign sigma   = r_sigma;
    assign head    = r_head;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= RES_NONE;
            r_q         <= '0;
            r_sym       <= '0;
            r_addr      <= '0;
            r_head      <= '0;
            r_steps     <= '0;
            r_sigma     <= '0;
            r_wrapped   <= 1'b0;
            r_stop_pend <= 1'b0;
            r_acked     <= 1'b0;
            r_ena_q     <= 1'b0;
        end else begin
            r_ena_q <= mem.m_ena;
            r_acked <= (r_state == w_state_nxt) && (r_acked || mem.m_ack);
            if (busy && stop) r_stop_pend <= 1'b1;
            case (r_state)
                IDLE: if (start) begin
                    r_steps     <= '0;
                    r_sigma     <= '0;
                    r_wrapped   <= 1'b0;
                    r_result    <= RES_NONE;
                    r_addr      <= '0;
                    r_stop_pend <= 1'b0;
                end
                CLRW: if (!mem.m_busy) begin
                    if (w_stop_any) begin
                        r_result <= RES_STOP;
                    end else if (r_addr == '1) begin
                        r_addr <= A_MID;
                        r_head <= A_MID;
                        r_q    <= '0;
                    end else begin
                        r_addr <= r_addr + ABITS'(1);
                    end
                end
                RD: if (w_ram_re) r_sym <= mem.rd_data;
                STEP: begin
                    r_steps <= w_steps_inc;
                    if (r_sym == '0 && w_rule.newsym != '0)
                        r_sigma <= r_sigma + CBITS'(1);
                    else if (r_sym != '0 && w_rule.newsym == '0)
                        r_sigma <= r_sigma - CBITS'(1);
                    r_head <= w_head_nxt;
                    r_addr <= w_head_nxt;
                    if (w_cross) r_wrapped <= 1'b1;
                    r_q <= w_rule.next;
                    if (w_step_result != RES_NONE) r_result <= w_step_result;
                end
                default: ;
            endcase
        end
    end
endmodule
